// File: rtl/handshake_sender_pkg.sv
// handshake_sender_pkg
//   Constants and types shared by the handshake sender and the opponent's
//   handshake receiver: sync nibble, message codes, frame length, sender
//   state encoding and a frame-builder helper.
package handshake_sender_pkg;

  localparam logic [3:0] HS_SYNC          = 4'b0111;
  localparam logic [3:0] HS_CODE_ACK      = 4'b0101;
  localparam logic [3:0] HS_CODE_GAME_END = 4'b1110;
  localparam int         HS_FRAME_BITS    = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } hs_tx_state_t;

  // Frame layout, MSB first on the line: sync[3:0], code[3:0], even parity.
  function automatic logic [HS_FRAME_BITS-1:0] hs_build_frame(
    input logic [3:0] sync,
    input logic [3:0] code
  );
    return {sync, code, ^code};
  endfunction

endpackage

// File: rtl/handshake_sender_if.sv
// handshake_sender_if
//   Groups the sender's request inputs and serial-line outputs.
//   master : the serializer (consumes requests, drives the line)
//   slave  : the requesting FSM / line observer
//   Signals: send_ready, send_game_lost (level requests),
//            handshake_out (serial line), tx_busy, frame_sent.
interface handshake_sender_if;
  logic send_ready;
  logic send_game_lost;
  logic handshake_out;
  logic tx_busy;
  logic frame_sent;

  modport master (
    input  send_ready,
    input  send_game_lost,
    output handshake_out,
    output tx_busy,
    output frame_sent
  );

  modport slave (
    output send_ready,
    output send_game_lost,
    input  handshake_out,
    input  tx_busy,
    input  frame_sent
  );
endinterface

// File: rtl/handshake_sender.sv
// handshake_sender
//   Serializes the level requests send_ready / send_game_lost into 9-bit
//   framed codes (sync, code, parity) on handshake_out, repeating with a
//   GAP_CYCLES idle gap while a request is held.
//   Ports:
//     clk    - GPIO clock
//     rst_l  - asynchronous active-low reset
//     hs     - handshake_sender_if.master (requests in; line, tx_busy,
//              frame_sent out; all outputs registered)
module handshake_sender
  import handshake_sender_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 8,
  parameter logic [3:0]  SYNC_PATTERN = HS_SYNC
) (
  input  logic                clk,
  input  logic                rst_l,
  handshake_sender_if.master  hs
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);
  localparam logic [3:0] BIT_LOAD = 4'(HS_FRAME_BITS - 1);

  hs_tx_state_t             state_reg,   state_next;
  logic [HS_FRAME_BITS-1:0] shreg_reg,   shreg_next;
  logic [3:0]               bit_cnt_reg, bit_cnt_next;
  logic [7:0]               gap_cnt_reg, gap_cnt_next;
  logic                     out_reg,     out_next;
  logic                     busy_reg,    busy_next;
  logic                     sent_reg,    sent_next;

  logic                     request;
  logic                     start_frame;
  logic [3:0]               code_sel;
  logic [HS_FRAME_BITS-1:0] frame_word;

  // Game-lost wins when both requests are up.
  assign request    = hs.send_ready | hs.send_game_lost;
  assign code_sel   = hs.send_game_lost ? HS_CODE_GAME_END : HS_CODE_ACK;
  assign frame_word = hs_build_frame(SYNC_PATTERN, code_sel);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      out_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      sent_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      bit_cnt_reg <= bit_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      out_reg     <= out_next;
      busy_reg    <= busy_next;
      sent_reg    <= sent_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    out_next     = out_reg;
    busy_next    = busy_reg;
    sent_next    = 1'b0;
    start_frame  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        out_next  = 1'b0;
        busy_next = 1'b0;
        if (request) start_frame = 1'b1;
      end

      FRAME: begin
        if (bit_cnt_reg != 4'd0) begin
          // shreg holds the bits not yet on the line, next one at the top.
          out_next     = shreg_reg[HS_FRAME_BITS-1];
          shreg_next   = shreg_reg << 1;
          bit_cnt_next = bit_cnt_reg - 4'd1;
          sent_next    = (bit_cnt_reg == 4'd1);  // parity goes out next
        end else begin
          out_next     = 1'b0;
          gap_cnt_next = GAP_LOAD;
          state_next   = GAP;
        end
      end

      GAP: begin
        out_next     = 1'b0;
        gap_cnt_next = (gap_cnt_reg != 8'd0) ? gap_cnt_reg - 8'd1 : 8'd0;
        // gap_cnt==1 marks the last gap cycle; the next frame (if any)
        // starts on this edge with no dead cycle.
        if (gap_cnt_reg <= 8'd1) begin
          if (request) begin
            start_frame = 1'b1;
          end else begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end
      end

      default: begin
        state_next = IDLE;
        out_next   = 1'b0;
        busy_next  = 1'b0;
      end
    endcase

    if (start_frame) begin
      out_next     = frame_word[HS_FRAME_BITS-1];
      shreg_next   = frame_word << 1;
      bit_cnt_next = BIT_LOAD;
      busy_next    = 1'b1;
      state_next   = FRAME;
    end
  end

  assign hs.handshake_out = out_reg;
  assign hs.tx_busy       = busy_reg;
  assign hs.frame_sent    = sent_reg;

endmodule
